// File: rtl/wb_b3_pkg.sv
// Shared encodings and helpers for the Wishbone B3 burst master: cycle-type and
// burst-type codes, the master FSM states and the burst length decode.
package wb_b3_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Request length codes double as the wrap burst type driven on bte.
  typedef enum logic [1:0] {
    BTE_LIN    = 2'b00,
    BTE_WRAP4  = 2'b01,
    BTE_WRAP8  = 2'b10,
    BTE_WRAP16 = 2'b11
  } bte_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_e;

  function automatic logic [4:0] beats_for_len(input logic [1:0] len);
    case (len)
      2'b00:   return 5'd1;
      2'b01:   return 5'd4;
      2'b10:   return 5'd8;
      default: return 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/wb_b3_rd_fifo.sv
// Synchronous read-data FIFO holding {last, data}; the occupancy count lets the
// master refuse a read request the FIFO could not absorb in full.
module wb_b3_rd_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [DW:0]                push_data_i,
  input  logic                       pop_i,
  output logic [DW:0]                pop_data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  // A pop only counts against a non-empty FIFO; a push into a full FIFO needs a pop.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full | do_pop);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/wb_b3_burst_master.sv
// Wishbone B3 master: turns one request into a classic cycle or a registered-feedback
// wrap burst and buffers read beats in a FIFO so the consumer can stall freely.
module wb_b3_burst_master
  import wb_b3_pkg::*;
#(
  parameter int dw         = 32,
  parameter int aw         = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [aw-1:0] req_adr_i,
  input  logic          req_we_i,
  input  logic [1:0]    req_len_i,
  input  logic          wr_valid_i,
  input  logic [dw-1:0] wr_data_i,
  input  logic [3:0]    wr_sel_i,
  output logic          wr_ready_o,
  output logic          rd_valid_o,
  output logic [dw-1:0] rd_data_o,
  output logic          rd_last_o,
  input  logic          rd_ready_i,
  output logic          done_o,
  output logic          err_o,
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic [1:0]    wb_bte_o,
  output logic [2:0]    wb_cti_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int WW = aw - 2;

  state_e        state_q, state_d;
  logic [aw-1:0] adr_q, adr_d;
  logic          we_q, we_d;
  bte_e          len_q, len_d;
  logic [3:0]    beat_q, beat_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          out_en_q;

  logic          bus, stb, last_beat, accept, push, space_ok;
  logic [4:0]    beats_cur;
  logic [3:0]    beats_m1;
  logic [WW-1:0] word, wrap_mask, word_next;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [dw:0]   fifo_head;
  logic          unused_adr_bits;

  assign unused_adr_bits = ^req_adr_i[1:0];

  assign bus       = (state_q == ST_BUS);
  assign beats_cur = beats_for_len(len_q);
  assign beats_m1  = 4'(beats_cur - 5'd1);
  assign last_beat = (beat_q == beats_m1);
  // Reads strobe every cycle of the burst; writes strobe only while data is offered.
  assign stb       = bus & (~we_q | wr_valid_i);

  assign space_ok    = (32'(FIFO_DEPTH) - 32'(fifo_count)) >= 32'(beats_for_len(req_len_i));
  assign req_ready_o = out_en_q & ~bus & (req_we_i | space_ok);
  assign accept      = req_valid_i & req_ready_o;

  // Wrap: only the low log2(beats) bits of the word index advance, matching the slave.
  assign word      = adr_q[aw-1:2];
  assign wrap_mask = WW'(beats_m1);
  assign word_next = (word & ~wrap_mask) | ((word + WW'(1)) & wrap_mask);

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path infers a latch.
    state_d = state_q;
    adr_d   = adr_q;
    we_d    = we_q;
    len_d   = len_q;
    beat_d  = beat_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_BUS;
          adr_d   = {req_adr_i[aw-1:2], 2'b00};
          we_d    = req_we_i;
          len_d   = bte_e'(req_len_i);
          beat_d  = 4'd0;
        end
      end
      ST_BUS: begin
        if (stb && (wb_err_i || wb_rty_i)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (stb && wb_ack_i) begin
          beat_d = beat_q + 4'd1;
          adr_d  = {word_next, 2'b00};
          push   = ~we_q;
          if (last_beat) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q  <= ST_IDLE;
      adr_q    <= '0;
      we_q     <= 1'b0;
      len_q    <= BTE_LIN;
      beat_q   <= 4'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      out_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      we_q     <= we_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      done_q   <= done_d;
      err_q    <= err_d;
      out_en_q <= 1'b1;
    end
  end

  always_comb begin
    wb_cti_o = CTI_CLASSIC;
    if (bus && len_q != BTE_LIN) wb_cti_o = last_beat ? CTI_EOB : CTI_INCR;
  end

  assign wb_cyc_o   = bus;
  assign wb_stb_o   = stb;
  assign wb_adr_o   = adr_q;
  assign wb_we_o    = bus & we_q;
  assign wb_bte_o   = bus ? len_q : BTE_LIN;
  assign wb_dat_o   = (bus & we_q) ? wr_data_i : '0;
  assign wb_sel_o   = (bus & we_q) ? wr_sel_i : '0;
  assign wr_ready_o = stb & we_q & wb_ack_i;
  assign done_o     = done_q;
  assign err_o      = err_q;

  wb_b3_rd_fifo #(
    .DW    (dw),
    .DEPTH (FIFO_DEPTH)
  ) u_rd_fifo (
    .clk_i       (wb_clk_i),
    .rst_ni      (wb_rst_ni),
    .push_i      (push),
    .push_data_i ({last_beat, wb_dat_i}),
    .pop_i       (rd_ready_i),
    .pop_data_o  (fifo_head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign rd_valid_o = ~fifo_empty;
  assign rd_data_o  = fifo_empty ? '0 : fifo_head[dw-1:0];
  assign rd_last_o  = ~fifo_empty & fifo_head[dw];

endmodule

// File: tb/tb_wb_b3_burst_master.sv
// Randomized bench for wb_b3_burst_master: a memory slave with injectable error/retry and
// a transaction-level model (expected beat addresses, memory image, read-data queue).
module tb_wb_b3_burst_master;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid_i = 1'b0, req_ready_o;
  logic [31:0] req_adr_i = '0;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_len_i = '0;
  logic        wr_valid_i = 1'b0, wr_ready_o;
  logic [31:0] wr_data_i = '0;
  logic [3:0]  wr_sel_i = '0;
  logic        rd_valid_o, rd_last_o, rd_ready_i = 1'b0;
  logic [31:0] rd_data_o;
  logic        done_o, err_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i, wb_rty_i;
  logic [1:0]  wb_bte_o;
  logic [2:0]  wb_cti_o;

  wb_b3_burst_master #(.dw(32), .aw(32), .FIFO_DEPTH(DEPTH)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_adr_i(req_adr_i),
    .req_we_i(req_we_i), .req_len_i(req_len_i),
    .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i), .wr_sel_i(wr_sel_i), .wr_ready_o(wr_ready_o),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_last_o(rd_last_o), .rd_ready_i(rd_ready_i),
    .done_o(done_o), .err_o(err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_bte_o(wb_bte_o), .wb_cti_o(wb_cti_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [9:0] idx);
    return {6'h2B, idx, 6'h15, idx};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // ---------------- reference model state ----------------
  typedef struct packed { logic [31:0] d; logic [3:0] s; } wbeat_t;
  typedef struct packed { logic last; logic [31:0] d; } rent_t;

  int     beats_tab [4] = '{1, 4, 8, 16};
  logic [31:0] ref_mem [1024];
  wbeat_t wq[$];
  rent_t  fq[$];
  bit     busy = 0, pending = 0, m_we = 0, m_live = 0;
  bit     exp_done = 0, exp_err = 0;
  logic [1:0] m_len = '0;
  int     m_base = 0, m_beat = 0, m_beats = 1;
  bit     ev_acc, ev_ack, ev_abort, ev_pop;
  int     gap_mode = 0, hold_left = 0, cyc_n = 0;

  // ---------------- memory slave with error/retry injection ----------------
  logic [31:0] smem [1024];
  bit          swritten [1024];
  bit          grant = 0, err_kind = 0;
  int          err_beat_cur = -1;
  logic [9:0]  widx;
  logic        slv_hit, slv_err;
  logic [31:0] slv_old, slv_wdata;

  always_comb begin
    widx      = wb_adr_o[11:2];
    slv_hit   = wb_cyc_o & wb_stb_o;
    slv_err   = slv_hit & (err_beat_cur == m_beat);
    wb_ack_i  = slv_hit & grant & ~slv_err;
    wb_err_i  = slv_err & ~err_kind;
    wb_rty_i  = slv_err & err_kind;
    slv_old   = swritten[widx] ? smem[widx] : pat(widx);
    wb_dat_i  = slv_old;
    slv_wdata = merge(slv_old, wb_dat_o, wb_sel_o);
  end

  always @(posedge clk) begin
    if (slv_hit && wb_ack_i && wb_we_o) begin
      smem[widx]     <= slv_wdata;
      swritten[widx] <= 1'b1;
    end
  end

  // Word index of beat k: low log2(n) bits count up from the start modulo n.
  function automatic int exp_word(input int k);
    int n;
    n = m_beats;
    return (m_base & ~(n - 1)) | ((m_base + k) & (n - 1));
  endfunction

  task automatic monitor();
    bit exp_rdy, exp_stb;
    exp_rdy = m_live && !busy && (req_we_i || (DEPTH - fq.size()) >= beats_tab[req_len_i]);
    check("req_ready", req_ready_o, exp_rdy);
    check("cyc", wb_cyc_o, busy);
    check("done", done_o, exp_done);
    check("err", err_o, exp_err);
    check("rd_valid", rd_valid_o, fq.size() != 0);
    if (fq.size() != 0) begin
      check("rd_data", rd_data_o, fq[0].d);
      check("rd_last", rd_last_o, fq[0].last);
    end
    ev_abort = 0; ev_ack = 0;
    if (busy) begin
      exp_stb = m_we ? wr_valid_i : 1'b1;
      check("stb", wb_stb_o, exp_stb);
      check("adr", wb_adr_o, 32'(exp_word(m_beat)) << 2);
      check("cti", wb_cti_o, (m_len == 2'b00) ? 3'b000 : (m_beat == m_beats - 1) ? 3'b111 : 3'b010);
      check("bte", wb_bte_o, m_len);
      check("we", wb_we_o, m_we);
      if (m_we && exp_stb && wq.size() != 0) begin
        check("wdat", wb_dat_o, wq[0].d);
        check("wsel", wb_sel_o, wq[0].s);
      end
      check("wr_ready", wr_ready_o, m_we && wb_ack_i);
      if (wb_err_i || wb_rty_i) ev_abort = 1;
      else if (wb_ack_i) ev_ack = 1;
    end else begin
      check("stb_idle", wb_stb_o, 1'b0);
    end
    ev_pop = (fq.size() != 0) && rd_ready_i;
    ev_acc = exp_rdy && req_valid_i;
  endtask

  task automatic apply();
    int     w;
    wbeat_t b;
    exp_done = 0;
    exp_err  = 0;
    if (ev_pop) void'(fq.pop_front());
    if (ev_abort) begin
      busy = 0; exp_err = 1; wq.delete();
    end else if (ev_ack) begin
      w = exp_word(m_beat);
      if (m_we) begin
        b = wq.pop_front();
        ref_mem[w] = merge(ref_mem[w], b.d, b.s);
      end else begin
        fq.push_back('{last: (m_beat == m_beats - 1), d: ref_mem[w]});
      end
      m_beat++;
      if (m_beat == m_beats) begin busy = 0; exp_done = 1; end
    end
    if (ev_acc) begin
      busy = 1; pending = 0; m_we = req_we_i; m_len = req_len_i;
      m_beats = beats_tab[req_len_i]; m_base = int'(req_adr_i[11:2]); m_beat = 0;
    end
    m_live = 1;
  endtask

  task automatic drive();
    bit gap_ok;
    case (gap_mode)
      0:       gap_ok = 1;
      1:       gap_ok = (cyc_n % 3) != 2;
      default: gap_ok = 1'($urandom_range(0, 1));
    endcase
    req_valid_i = pending;
    wr_valid_i  = busy && m_we && wq.size() != 0 && gap_ok;
    wr_data_i   = (wq.size() != 0) ? wq[0].d : $urandom;
    wr_sel_i    = (wq.size() != 0) ? wq[0].s : 4'($urandom_range(0, 15));
    grant       = ($urandom_range(0, 9) < 7);
    rd_ready_i  = (hold_left > 0) ? 1'b0 : 1'($urandom_range(0, 1));
    if (hold_left > 0) hold_left--;
    cyc_n++;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    apply();
    drive();
  endtask

  task automatic start_req(input logic [31:0] adr, input logic we, input logic [1:0] len,
                           input int errb, input int gap);
    req_adr_i = adr; req_we_i = we; req_len_i = len;
    err_beat_cur = errb; err_kind = 1'($urandom_range(0, 1)); gap_mode = gap;
    wq.delete();
    if (we) for (int i = 0; i < beats_tab[len]; i++)
      wq.push_back('{d: $urandom, s: 4'($urandom_range(1, 15))});
    pending = 1; req_valid_i = 1'b1;
  endtask

  task automatic run_req(input logic [31:0] adr, input logic we, input logic [1:0] len,
                         input int errb, input int gap);
    start_req(adr, we, len, errb, gap);
    for (int lim = 0; lim < 600 && (pending || busy); lim++) tick();
    check("req_timeout", pending || busy, 1'b0);
  endtask

  task automatic drain();
    hold_left = 0;
    for (int lim = 0; lim < 300 && fq.size() != 0; lim++) tick();
    check("drain_timeout", fq.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = pat(10'(i));

    #12;
    check("rst_cyc", wb_cyc_o, 1'b0);
    check("rst_stb", wb_stb_o, 1'b0);
    check("rst_ready", req_ready_o, 1'b0);
    check("rst_rd_valid", rd_valid_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_cti", wb_cti_o, 3'b000);
    check("rst_adr", wb_adr_o, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive();

    // Directed scenarios.
    run_req(32'h18, 1'b0, 2'b01, -1, 0);
    run_req(32'h3C, 1'b1, 2'b11, -1, 1);
    run_req(32'h100, 1'b0, 2'b00, -1, 0);
    drain();
    hold_left = 100000;
    run_req(32'h40, 1'b0, 2'b10, -1, 0);
    run_req(32'h80, 1'b0, 2'b00, -1, 0);
    run_req(32'h84, 1'b0, 2'b00, -1, 0);
    hold_left = 25;
    run_req(32'h200, 1'b0, 2'b10, -1, 0);
    drain();
    run_req(32'h120, 1'b0, 2'b10, 2, 0);
    drain();
    run_req(32'h120, 1'b0, 2'b10, -1, 0);

    // Randomized traffic.
    for (int r = 0; r < 60; r++) begin
      logic [31:0] a;
      logic        w;
      logic [1:0]  l;
      int          eb;
      a  = 32'($urandom_range(0, 4095));
      w  = 1'($urandom_range(0, 1));
      l  = 2'($urandom_range(0, 3));
      eb = ($urandom_range(0, 5) == 0) ? $urandom_range(0, beats_tab[l] - 1) : -1;
      run_req(a, w, l, eb, $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) tick();
    end
    drain();

    // Reset in the middle of a 16-beat write with read data still buffered.
    hold_left = 100000;
    run_req(32'h300, 1'b0, 2'b01, -1, 0);
    start_req(32'h3C0, 1'b1, 2'b11, -1, 0);
    for (int lim = 0; lim < 200 && !(busy && m_beat >= 5); lim++) tick();
    check("mid_burst_reached", busy && m_beat >= 5, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cyc", wb_cyc_o, 1'b0);
    check("arst_stb", wb_stb_o, 1'b0);
    check("arst_done", done_o, 1'b0);
    check("arst_err", err_o, 1'b0);
    check("arst_rd_valid", rd_valid_o, 1'b0);
    check("arst_ready", req_ready_o, 1'b0);
    busy = 0; pending = 0; exp_done = 0; exp_err = 0; m_live = 0;
    wq.delete(); fq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold_left = 0;
    drive();
    repeat (3) tick();
    run_req(32'h3C0, 1'b0, 2'b11, -1, 0);
    run_req(32'h44, 1'b1, 2'b00, -1, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
